// File: rtl/con_host_pkg.sv
// Shared types for the board-side con_* bus port: FSM state encoding, beat layout and
// bandwidth counter width.
`timescale 1ns/1ps
package con_host_pkg;

  localparam int CON_LANE_W   = 16;
  localparam int BW_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RECV = 2'd2,
    ST_TURN = 2'd3
  } con_host_state_t;

  // Packed so that the vector view is {lane3, lane2, lane1}, matching src_data/snk_data.
  typedef struct packed {
    logic [CON_LANE_W-1:0] lane3;
    logic [CON_LANE_W-1:0] lane2;
    logic [CON_LANE_W-1:0] lane1;
  } con_beat_t;

endpackage

// File: rtl/con_host_port_if.sv
// Local-side streams of con_host_port: source beats in (memory reader), captured beats out
// (memory writer). Both follow valid/ready: a beat moves on a rising edge where valid & ready.
`timescale 1ns/1ps
interface con_host_port_if #(
  parameter int W = 16
);
  logic           src_valid;
  logic           src_ready;
  logic [3*W-1:0] src_data;
  logic           snk_valid;
  logic           snk_ready;
  logic [3*W-1:0] snk_data;

  // master: the local reader/writer side; slave: con_host_port itself.
  modport master (
    output src_valid, src_data, snk_ready,
    input  src_ready, snk_valid, snk_data
  );

  modport slave (
    input  src_valid, src_data, snk_ready,
    output src_ready, snk_valid, snk_data
  );
endinterface

// File: rtl/con_host_fifo.sv
// Synchronous first-word-fall-through FIFO; head is valid whenever count != 0.
// Pops on an empty FIFO are ignored; a push on a full FIFO lands only if a pop frees a slot.
`timescale 1ns/1ps
module con_host_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       arst_in,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly AW bits wide, so wrapping modulo DEPTH is free.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/con_host_port.sv
// Board-side end of the con_1/2/3 tri-state bus: TX FIFO onto the bus, capture FIFO off it.
// Optional bandwidth counters when CON_HOST_BW_COUNT_EN is defined.
`timescale 1ns/1ps
module con_host_port
  import con_host_pkg::*;
#(
  parameter int IO_DATA_WIDTH = 16,
  parameter int TX_DEPTH      = 4,
  parameter int RX_DEPTH      = 4,
  parameter int TURN_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     arst_in,
  con_host_port_if.slave           loc,
  inout  wire  [IO_DATA_WIDTH-1:0] con_1,
  inout  wire  [IO_DATA_WIDTH-1:0] con_2,
  inout  wire  [IO_DATA_WIDTH-1:0] con_3,
  output logic                     con_valid,
  input  logic                     con_ready,
  input  logic                     driving_cons,
  input  logic                     output_valid,
  output logic                     rx_overflow,
`ifdef CON_HOST_BW_COUNT_EN
  output logic [BW_CNT_WIDTH-1:0]  bw_tx_words,
  output logic [BW_CNT_WIDTH-1:0]  bw_rx_words,
`endif
  output con_host_state_t          dbg_state,
  output logic                     dbg_oe
);
  localparam int W    = IO_DATA_WIDTH;
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW  = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  con_host_state_t state;
  logic [TCW-1:0]  turn_cnt;

  logic [3*W-1:0]  tx_head;
  logic            tx_full;
  logic [TXCW-1:0] tx_count;
  logic [TXCW-1:0] tx_count_nxt;
  logic            tx_push;
  logic            tx_pop;
  logic            tx_nonempty_nxt;

  logic [3*W-1:0]  rx_head;
  logic            rx_full;
  logic [RXCW-1:0] rx_count;
  logic            rx_req;
  logic            rx_pop;
  logic            rx_accept;
  logic            oe;

  // Release is combinational so the host lets go in the same cycle the chip claims the bus.
  assign oe        = (state == ST_SEND) & ~driving_cons;
  assign con_valid = oe & (tx_count != '0);
  assign tx_pop    = con_valid & con_ready;

  assign loc.src_ready = ~arst_in & ~tx_full;
  assign tx_push       = loc.src_valid & loc.src_ready;

  assign con_1 = oe ? tx_head[W-1:0]     : {W{1'bz}};
  assign con_2 = oe ? tx_head[2*W-1:W]   : {W{1'bz}};
  assign con_3 = oe ? tx_head[3*W-1:2*W] : {W{1'bz}};

  assign rx_req        = driving_cons & output_valid;
  assign loc.snk_valid = (rx_count != '0);
  assign loc.snk_data  = rx_head;
  assign rx_pop        = loc.snk_valid & loc.snk_ready;
  assign rx_accept     = rx_req & (~rx_full | rx_pop);

  assign dbg_state = state;
  assign dbg_oe    = oe;

  // Look ahead one edge so a beat pushed while idle is on the bus the very next cycle.
  always_comb begin
    tx_count_nxt = tx_count;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_nxt = tx_count + TXCW'(1);
      2'b01:   tx_count_nxt = tx_count - TXCW'(1);
      default: tx_count_nxt = tx_count;
    endcase
  end
  assign tx_nonempty_nxt = (tx_count_nxt != '0);

  con_host_fifo #(.WIDTH(3*W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .arst_in   (arst_in),
    .push      (tx_push),
    .push_data (loc.src_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .count     (tx_count)
  );

  con_host_fifo #(.WIDTH(3*W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .arst_in   (arst_in),
    .push      (rx_req),
    .push_data ({con_3, con_2, con_1}),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .count     (rx_count)
  );

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state       <= ST_IDLE;
      turn_cnt    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_req & ~rx_accept) rx_overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (driving_cons)         state <= ST_RECV;
          else if (tx_nonempty_nxt) state <= ST_SEND;
        end
        ST_SEND: begin
          if (driving_cons)          state <= ST_RECV;
          else if (!tx_nonempty_nxt) state <= ST_IDLE;
        end
        ST_RECV: begin
          if (!driving_cons) begin
            state    <= ST_TURN;
            turn_cnt <= TCW'(TURN_CYCLES - 1);
          end
        end
        ST_TURN: begin
          if (driving_cons)        state <= ST_RECV;
          else if (turn_cnt == '0) state <= tx_nonempty_nxt ? ST_SEND : ST_IDLE;
          else                     turn_cnt <= turn_cnt - TCW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CON_HOST_BW_COUNT_EN
  localparam logic [BW_CNT_WIDTH-1:0] BW_MAX = '1;
  localparam logic [BW_CNT_WIDTH-1:0] BW_LIM = BW_MAX - BW_CNT_WIDTH'(3);

  // Three lanes per beat; dropped capture beats are not counted.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      bw_tx_words <= '0;
      bw_rx_words <= '0;
    end else begin
      if (tx_pop)    bw_tx_words <= (bw_tx_words > BW_LIM) ? BW_MAX : bw_tx_words + BW_CNT_WIDTH'(3);
      if (rx_accept) bw_rx_words <= (bw_rx_words > BW_LIM) ? BW_MAX : bw_rx_words + BW_CNT_WIDTH'(3);
    end
  end
`endif

endmodule

// File: tb/tb_con_host_port.sv
// Directed self-checking bench for con_host_port (default parameters: W=16, depths 4, TURN_CYCLES=1).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
`timescale 1ns/1ps
module tb_con_host_port;
  import con_host_pkg::*;

  logic        clk = 1'b0;
  logic        arst_in;
  logic        con_ready;
  logic        driving_cons;
  logic        output_valid;
  logic        con_valid;
  logic        rx_overflow;
  logic        dbg_oe;
  con_host_state_t dbg_state;
  logic [15:0] chip_1, chip_2, chip_3;
  wire  [15:0] con_1, con_2, con_3;
`ifdef CON_HOST_BW_COUNT_EN
  logic [31:0] bw_tx_words, bw_rx_words;
`endif

  int checks   = 0;
  int failures = 0;
  logic [47:0] exp_q[$];

  con_host_port_if #(.W(16)) loc ();

  // Chip model: drives the lanes only while it owns the bus.
  assign con_1 = driving_cons ? chip_1 : 16'bz;
  assign con_2 = driving_cons ? chip_2 : 16'bz;
  assign con_3 = driving_cons ? chip_3 : 16'bz;

  con_host_port dut (
    .clk          (clk),
    .arst_in      (arst_in),
    .loc          (loc.slave),
    .con_1        (con_1),
    .con_2        (con_2),
    .con_3        (con_3),
    .con_valid    (con_valid),
    .con_ready    (con_ready),
    .driving_cons (driving_cons),
    .output_valid (output_valid),
    .rx_overflow  (rx_overflow),
`ifdef CON_HOST_BW_COUNT_EN
    .bw_tx_words  (bw_tx_words),
    .bw_rx_words  (bw_rx_words),
`endif
    .dbg_state    (dbg_state),
    .dbg_oe       (dbg_oe)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    loc.src_valid = 1'b0;
    loc.src_data  = '0;
    loc.snk_ready = 1'b0;
    con_ready     = 1'b0;
    driving_cons  = 1'b0;
    output_valid  = 1'b0;
    chip_1 = '0; chip_2 = '0; chip_3 = '0;
  endtask

  task automatic chip_beat(input logic [47:0] b);
    driving_cons = 1'b1;
    output_valid = 1'b1;
    {chip_3, chip_2, chip_1} = b;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst_in = 1'b1;
    drive_idle();
    @(negedge clk); #1;
    checks++;
    if ({loc.src_ready, con_valid, dbg_oe, loc.snk_valid, rx_overflow} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got src_ready/con_valid/oe/snk_valid/ovf=%b, want 00000",
               {loc.src_ready, con_valid, dbg_oe, loc.snk_valid, rx_overflow});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    @(negedge clk); arst_in = 1'b0; #1;
    checks++;
    if (loc.src_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_src_ready: got %b want 1", loc.src_ready);
    end
  endtask

  task automatic test_stream();
    logic [47:0] beats[3];
    logic [47:0] e;
    beats[0] = 48'h0a03_0a02_0a01;
    beats[1] = 48'h0b03_0b02_0b01;
    beats[2] = 48'h0c03_0c02_0c01;
    con_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      loc.src_valid = (c < 3);
      loc.src_data  = (c < 3) ? beats[c] : '0;
      if (c < 3) exp_q.push_back(beats[c]);
      #1;
      if (c >= 1 && c <= 3) begin
        e = exp_q.pop_front();
        checks++;
        if ({con_valid, con_3, con_2, con_1} !== {1'b1, e}) begin
          failures++;
          $display("FAIL stream_beat%0d: got valid=%b data=%h, want valid=1 data=%h",
                   c - 1, con_valid, {con_3, con_2, con_1}, e);
        end
      end
    end
    checks++;
    if (con_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL stream_end: got valid=%b state=%0d, want valid=0 state=%0d",
               con_valid, dbg_state, ST_IDLE);
    end
    con_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [47:0] a;
    a = 48'h3333_2222_1111;
    @(negedge clk);
    loc.src_valid = 1'b1; loc.src_data = a; con_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      loc.src_valid = 1'b0;
      con_ready = (c == 6);
      #1;
      checks++;
      if ({con_valid, con_3, con_2, con_1} !== {1'b1, a}) begin
        failures++;
        $display("FAIL stall_hold_c%0d: got valid=%b data=%h, want valid=1 data=%h",
                 c, con_valid, {con_3, con_2, con_1}, a);
      end
    end
    @(negedge clk); con_ready = 1'b0; #1;
    checks++;
    if (con_valid !== 1'b0) begin
      failures++; $display("FAIL stall_accepted: got valid=%b want 0", con_valid);
    end
  endtask

  task automatic test_chip_claim();
    logic [47:0] x;
    x = 48'h00c3_00b2_00a1;
    @(negedge clk);
    loc.src_valid = 1'b1; loc.src_data = x; con_ready = 1'b0;
    @(negedge clk); loc.src_valid = 1'b0; #1;
    checks++;
    if (con_valid !== 1'b1 || dbg_oe !== 1'b1) begin
      failures++; $display("FAIL claim_pre: got valid=%b oe=%b, want 1 1", con_valid, dbg_oe);
    end
    @(negedge clk);
    driving_cons = 1'b1; output_valid = 1'b0;
    chip_1 = 16'h5a01; chip_2 = 16'h5a02; chip_3 = 16'h5a03;
    #1;
    checks++;
    if (dbg_oe !== 1'b0 || con_valid !== 1'b0 || con_1 !== 16'h5a01) begin
      failures++;
      $display("FAIL claim_same_cycle: got oe=%b valid=%b con_1=%h, want oe=0 valid=0 con_1=5a01",
               dbg_oe, con_valid, con_1);
    end
    @(negedge clk); #1;
    checks++;
    if (dbg_state !== ST_RECV || con_valid !== 1'b0) begin
      failures++;
      $display("FAIL claim_recv: got state=%0d valid=%b, want state=%0d valid=0",
               dbg_state, con_valid, ST_RECV);
    end
    @(negedge clk); driving_cons = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (dbg_state !== ST_TURN || con_valid !== 1'b0 || dbg_oe !== 1'b0) begin
      failures++;
      $display("FAIL claim_turn: got state=%0d valid=%b oe=%b, want state=%0d valid=0 oe=0",
               dbg_state, con_valid, dbg_oe, ST_TURN);
    end
    @(negedge clk); con_ready = 1'b1; #1;
    checks++;
    if ({con_valid, con_3, con_2, con_1} !== {1'b1, x}) begin
      failures++;
      $display("FAIL claim_reoffer: got valid=%b data=%h, want valid=1 data=%h",
               con_valid, {con_3, con_2, con_1}, x);
    end
    @(negedge clk); con_ready = 1'b0; #1;
    checks++;
    if (con_valid !== 1'b0) begin
      failures++; $display("FAIL claim_done: got valid=%b want 0", con_valid);
    end
  endtask

  task automatic test_capture_overflow();
    logic [47:0] r[6];
    logic [47:0] e;
    for (int i = 0; i < 6; i++) r[i] = {16'h7003 + 16'(i << 4), 16'h7002 + 16'(i << 4), 16'h7001 + 16'(i << 4)};
    exp_q.delete();
    loc.snk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chip_beat(r[i]);
      if (i < 4) exp_q.push_back(r[i]);
      #1;
      checks++;
      if (rx_overflow !== 1'b0) begin
        failures++; $display("FAIL cap_no_ovf_%0d: got %b want 0", i, rx_overflow);
      end
    end
    @(negedge clk); driving_cons = 1'b0; output_valid = 1'b0; #1;
    checks++;
    if ({rx_overflow, loc.snk_valid, loc.snk_data} !== {2'b11, r[0]}) begin
      failures++;
      $display("FAIL cap_overflow: got ovf=%b snk_valid=%b data=%h, want 1 1 %h",
               rx_overflow, loc.snk_valid, loc.snk_data, r[0]);
    end
    // Full FIFO: a pop in the same cycle frees the slot for the new chip beat.
    @(negedge clk); chip_beat(r[5]); loc.snk_ready = 1'b1; #1;
    e = exp_q.pop_front();
    exp_q.push_back(r[5]);
    checks++;
    if (loc.snk_data !== e) begin
      failures++; $display("FAIL cap_full_pushpop: got %h want %h", loc.snk_data, e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); driving_cons = 1'b0; output_valid = 1'b0; loc.snk_ready = 1'b1; #1;
      e = exp_q.pop_front();
      checks++;
      if ({loc.snk_valid, loc.snk_data} !== {1'b1, e}) begin
        failures++;
        $display("FAIL cap_drain_%0d: got valid=%b data=%h, want valid=1 data=%h",
                 k, loc.snk_valid, loc.snk_data, e);
      end
    end
    @(negedge clk); loc.snk_ready = 1'b0; #1;
    checks++;
    if (loc.snk_valid !== 1'b0 || rx_overflow !== 1'b1) begin
      failures++;
      $display("FAIL cap_empty_sticky: got snk_valid=%b ovf=%b, want 0 1", loc.snk_valid, rx_overflow);
    end
  endtask

  task automatic test_reset_mid_send();
    @(negedge clk); chip_beat(48'h0e03_0e02_0e01);
    @(negedge clk); driving_cons = 1'b0; output_valid = 1'b0;
    @(negedge clk); loc.src_valid = 1'b1; loc.src_data = 48'h0d03_0d02_0d01; con_ready = 1'b0;
    @(negedge clk); loc.src_data = 48'h0f03_0f02_0f01;
    @(negedge clk); loc.src_valid = 1'b0; #1;
    checks++;
    if ({con_valid, loc.snk_valid, rx_overflow, con_3, con_2, con_1} !== {3'b111, 48'h0d03_0d02_0d01}) begin
      failures++;
      $display("FAIL rst_pre: got valid=%b snk_valid=%b ovf=%b data=%h, want 1 1 1 0d030d020d01",
               con_valid, loc.snk_valid, rx_overflow, {con_3, con_2, con_1});
    end
    @(negedge clk); arst_in = 1'b1; #1;
    checks++;
    if ({dbg_oe, con_valid, loc.snk_valid, loc.src_ready, rx_overflow} !== 5'b0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_async: got oe/valid/snk_valid/src_ready/ovf=%b state=%0d, want 00000 state=0",
               {dbg_oe, con_valid, loc.snk_valid, loc.src_ready, rx_overflow}, dbg_state);
    end
    @(negedge clk); arst_in = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if ({loc.src_ready, con_valid, loc.snk_valid} !== 3'b100) begin
      failures++;
      $display("FAIL rst_dropped: got src_ready/valid/snk_valid=%b, want 100",
               {loc.src_ready, con_valid, loc.snk_valid});
    end
  endtask

`ifdef CON_HOST_BW_COUNT_EN
  task automatic test_bw_count();
    con_ready = 1'b1;
    @(negedge clk); loc.src_valid = 1'b1; loc.src_data = 48'h1;
    @(negedge clk); loc.src_data = 48'h2;
    @(negedge clk); loc.src_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); con_ready = 1'b0; chip_beat(48'h3);
    @(negedge clk); driving_cons = 1'b0; output_valid = 1'b0; #1;
    checks++;
    if (bw_tx_words !== 32'd6 || bw_rx_words !== 32'd3) begin
      failures++;
      $display("FAIL bw_count: got tx=%0d rx=%0d, want tx=6 rx=3", bw_tx_words, bw_rx_words);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_chip_claim();
    test_capture_overflow();
    test_reset_mid_send();
`ifdef CON_HOST_BW_COUNT_EN
    test_bw_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
